// File: rtl/amp_spi_responder_pkg.sv
// Shared definitions for the amplifier SPI gain responder: frame width, gain codes, FSM states.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package amp_pkg;

    localparam int AMP_FRAME_W = 8;

    // 4-bit gain codes carried in each nibble of a frame
    localparam logic [3:0] GAIN_OFF  = 4'b0000;
    localparam logic [3:0] GAIN_M1   = 4'b0001;
    localparam logic [3:0] GAIN_M2   = 4'b0010;
    localparam logic [3:0] GAIN_M5   = 4'b0011;
    localparam logic [3:0] GAIN_M10  = 4'b0100;
    localparam logic [3:0] GAIN_M20  = 4'b0101;
    localparam logic [3:0] GAIN_M50  = 4'b0110;
    localparam logic [3:0] GAIN_M100 = 4'b0111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } resp_state_t;

    // Codes above GAIN_M100 are reserved on the real part.
    function automatic logic code_ok(input logic [7:0] frame);
        return (frame[7:4] <= 4'd7) && (frame[3:0] <= 4'd7);
    endfunction

endpackage

// File: rtl/amp_spi_responder_if.sv
// SPI gain-interface wires between the amplifier command initiator and its responder.
// Latency: n/a (wires only).
// Backpressure: none; the initiator owns sck/cs timing, the responder only echoes on amp_dout.
// Ports: spi_sck, spi_mosi, amp_cs (active low), amp_shdn (active high) from initiator; amp_dout back.
interface amp_spi_responder_if;
    logic spi_sck;
    logic spi_mosi;
    logic amp_cs;
    logic amp_shdn;
    logic amp_dout;

    modport master (output spi_sck, output spi_mosi, output amp_cs, output amp_shdn, input  amp_dout);
    modport slave  (input  spi_sck, input  spi_mosi, input  amp_cs, input  amp_shdn, output amp_dout);
endinterface

// File: rtl/amp_spi_responder_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with registered rise/fall pulses.
// Latency: STAGES + 1 clocks from input change to level/rise/fall outputs.
// Backpressure: none; pulses are single-cycle and must be consumed when asserted.
// Ports: clock, reset_n, din (async) -> level (synchronized), rise, fall (one-cycle pulses).
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    // Fewer than two stages is not metastability-safe, so clamp up.
    localparam int N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] sync_q;
    logic         hist_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[N-2:0], din};
            hist_q <= sync_q[N-1];
            rise   <= sync_q[N-1] & ~hist_q;
            fall   <= ~sync_q[N-1] & hist_q;
        end
    end

    // The history flop is cycle-aligned with the registered edge pulses.
    assign level = hist_q;

endmodule

// File: rtl/amp_spi_responder.sv
// SPI responder emulating the programmable amplifier: shifts in gain frames, echoes previous register.
// Latency: SYNC_STAGES + 2 clocks from an SPI pin edge to the resulting action; gain_valid/frame_error 1 clock after LATCH.
// Backpressure: none; the initiator paces frames, clock must be >= 4x spi_sck.
// Ports: clock, reset_n; spi (slave modport: sck, mosi, cs, shdn in, dout out);
//        gain_a, gain_b held codes; gain_valid / frame_error pulses; shutdown synchronized amp_shdn.
// Build option: define AMP_CODE_CHECK_EN to reject frames carrying reserved gain codes (nibble > 7).
module amp_spi_responder
    import amp_pkg::*;
#(
    parameter int FRAME_W     = AMP_FRAME_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    amp_spi_responder_if.slave   spi,
    output logic [3:0]           gain_a,
    output logic [3:0]           gain_b,
    output logic                 gain_valid,
    output logic                 frame_error,
    output logic                 shutdown
);

    logic sck_lvl,  sck_rise,  sck_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic cs_lvl,   cs_rise,   cs_fall;
    logic shdn_lvl, shdn_rise, shdn_fall;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck  (.clock(clock), .reset_n(reset_n), .din(spi.spi_sck),
                                                   .level(sck_lvl),  .rise(sck_rise),  .fall(sck_fall));
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (.clock(clock), .reset_n(reset_n), .din(spi.spi_mosi),
                                                   .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs   (.clock(clock), .reset_n(reset_n), .din(spi.amp_cs),
                                                   .level(cs_lvl),   .rise(cs_rise),   .fall(cs_fall));
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_shdn (.clock(clock), .reset_n(reset_n), .din(spi.amp_shdn),
                                                   .level(shdn_lvl), .rise(shdn_rise), .fall(shdn_fall));

    // Only the levels of mosi/shdn and the edges of sck/cs are meaningful here.
    logic unused_edges;
    assign unused_edges = ^{sck_lvl, mosi_rise, mosi_fall, shdn_rise, shdn_fall};

    resp_state_t            state_q, state_d;
    logic [AMP_FRAME_W-1:0] shift_q, shift_d;
    logic [AMP_FRAME_W-1:0] echo_q,  echo_d;
    logic [3:0]             cnt_q,   cnt_d;
    logic [3:0]             gain_a_d, gain_b_d;
    logic                   valid_d, err_d;
    logic                   frame_ok;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            echo_q      <= '0;
            cnt_q       <= '0;
            gain_a      <= '0;
            gain_b      <= '0;
            gain_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            echo_q      <= echo_d;
            cnt_q       <= cnt_d;
            gain_a      <= gain_a_d;
            gain_b      <= gain_b_d;
            gain_valid  <= valid_d;
            frame_error <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        echo_d   = echo_q;
        cnt_d    = cnt_q;
        gain_a_d = gain_a;
        gain_b_d = gain_b;
        valid_d  = 1'b0;
        err_d    = 1'b0;

`ifdef AMP_CODE_CHECK_EN
        frame_ok = (cnt_q == 4'(FRAME_W)) && code_ok(shift_q);
`else
        frame_ok = (cnt_q == 4'(FRAME_W));
`endif

        if (shdn_lvl) begin
            // Shutdown overrides everything: gains cleared, any frame dropped silently.
            state_d  = IDLE;
            gain_a_d = GAIN_OFF;
            gain_b_d = GAIN_OFF;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                        shift_d = '0;
                        echo_d  = {gain_b, gain_a};
                    end
                end
                SHIFT: begin
                    // cs rising takes priority over a coincident sck edge.
                    if (cs_rise) begin
                        state_d = LATCH;
                    end else if (sck_rise && !cs_lvl) begin
                        shift_d = {shift_q[AMP_FRAME_W-2:0], mosi_lvl};
                        if (cnt_q != 4'hF) begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (sck_fall && !cs_lvl) begin
                        echo_d = {echo_q[AMP_FRAME_W-2:0], 1'b0};
                    end
                end
                LATCH: begin
                    state_d = IDLE;
                    if (frame_ok) begin
                        gain_b_d = shift_q[7:4];
                        gain_a_d = shift_q[3:0];
                        valid_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Echo bit is only presented while a frame is being clocked.
    assign spi.amp_dout = (state_q == SHIFT) && echo_q[AMP_FRAME_W-1];
    assign shutdown     = shdn_lvl;

endmodule

// File: tb/tb_amp_spi_responder.sv
// Self-checking bench for amp_spi_responder: table of frames plus shutdown and reset sequences.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_amp_spi_responder;
    import amp_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] gain_a, gain_b;
    logic       gain_valid, frame_error, shutdown;

    amp_spi_responder_if spi_bus();

    amp_spi_responder dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .spi         (spi_bus.slave),
        .gain_a      (gain_a),
        .gain_b      (gain_b),
        .gain_valid  (gain_valid),
        .frame_error (frame_error),
        .shutdown    (shutdown)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       v;
        logic       e;
        logic [3:0] a;
        logic [3:0] b;
    } exp_t;

    typedef struct {
        logic [15:0] data;
        int          nbits;
        logic        v;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [7:0]  echo;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every gain_valid/frame_error pulse must match the oldest queued expectation.
    always @(negedge clock) begin : monitor
        exp_t x;
        if (reset_n && (gain_valid || frame_error)) begin
            check("pulse_exclusive", 16'(gain_valid & frame_error), 16'h0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got valid=%0b err=%0b, expected no pulse", gain_valid, frame_error);
            end else begin
                x = sb_q.pop_front();
                check("pulse_valid", 16'(gain_valid), 16'(x.v));
                check("pulse_error", 16'(frame_error), 16'(x.e));
                check("pulse_gain_a", 16'(gain_a), 16'(x.a));
                check("pulse_gain_b", 16'(gain_b), 16'(x.b));
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic frame_start();
        spi_bus.spi_sck = 1'b0;
        spi_bus.amp_cs  = 1'b0;
        wait_clk(8);
    endtask

    task automatic frame_end();
        wait_clk(8);
        spi_bus.amp_cs = 1'b1;
        wait_clk(8);
    endtask

    // sck period = 8 clocks; dout sampled mid-high-phase, MSB of the echo first.
    task automatic send_bits(input logic [15:0] data, input int nbits, input logic [7:0] echo, input bit chk);
        logic exp_bit;
        for (int i = 0; i < nbits; i++) begin
            spi_bus.spi_mosi = data[nbits-1-i];
            wait_clk(4);
            spi_bus.spi_sck = 1'b1;
            wait_clk(2);
            exp_bit = 1'b0;
            if (i < 8) exp_bit = echo[7-i];
            if (chk) check($sformatf("dout_bit%0d", i), 16'(spi_bus.amp_dout), 16'(exp_bit));
            wait_clk(2);
            spi_bus.spi_sck = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gain_a"}, 16'(gain_a), 16'h0);
        check({tag, "_gain_b"}, 16'(gain_b), 16'h0);
        check({tag, "_gain_valid"}, 16'(gain_valid), 16'h0);
        check({tag, "_frame_error"}, 16'(frame_error), 16'h0);
        check({tag, "_shutdown"}, 16'(shutdown), 16'h0);
        check({tag, "_amp_dout"}, 16'(spi_bus.amp_dout), 16'h0);
    endtask

    initial begin
        vecs[0] = '{16'h0011, 8, 1'b1, GAIN_M1, GAIN_M1, 8'h00};
        vecs[1] = '{16'h0033, 8, 1'b1, GAIN_M5, GAIN_M5, 8'h11};
        vecs[2] = '{16'h0015, 5, 1'b0, GAIN_M5, GAIN_M5, 8'h33};
        vecs[3] = '{16'h01AB, 9, 1'b0, GAIN_M5, GAIN_M5, 8'h33};
`ifdef AMP_CODE_CHECK_EN
        vecs[4] = '{16'h0019, 8, 1'b0, GAIN_M5, GAIN_M5, 8'h33};
        vecs[5] = '{16'h0075, 8, 1'b1, GAIN_M20, GAIN_M100, 8'h33};
`else
        vecs[4] = '{16'h0019, 8, 1'b1, 4'd9, GAIN_M1, 8'h33};
        vecs[5] = '{16'h0075, 8, 1'b1, GAIN_M20, GAIN_M100, 8'h19};
`endif
        vecs[6] = '{16'h0000, 0, 1'b0, GAIN_M20, GAIN_M100, 8'h75};

        spi_bus.spi_sck  = 1'b0;
        spi_bus.spi_mosi = 1'b0;
        spi_bus.amp_cs   = 1'b1;
        spi_bus.amp_shdn = 1'b0;
        reset_n = 1'b0;
        wait_clk(4);
        check_all_zero("in_reset");
        reset_n = 1'b1;
        wait_clk(8);
        check_all_zero("after_reset");

        // Table-driven frames
        foreach (vecs[k]) begin
            sb_q.push_back('{vecs[k].v, ~vecs[k].v, vecs[k].a, vecs[k].b});
            frame_start();
            send_bits(vecs[k].data, vecs[k].nbits, vecs[k].echo, 1'b1);
            frame_end();
            check($sformatf("vec%0d_gain_a", k), 16'(gain_a), 16'(vecs[k].a));
            check($sformatf("vec%0d_gain_b", k), 16'(gain_b), 16'(vecs[k].b));
            check($sformatf("vec%0d_pulse_seen", k), 16'(sb_q.size()), 16'h0);
        end

        // Shutdown mid-frame: gains forced to 0, frame aborted without a pulse
        frame_start();
        send_bits(16'h0003, 3, 8'h00, 1'b0);
        spi_bus.amp_shdn = 1'b1;
        wait_clk(8);
        check("shdn_level", 16'(shutdown), 16'h1);
        check("shdn_gain_a", 16'(gain_a), 16'h0);
        check("shdn_gain_b", 16'(gain_b), 16'h0);
        spi_bus.amp_shdn = 1'b0;
        wait_clk(8);
        send_bits(16'h0005, 5, 8'h00, 1'b0);
        frame_end();
        check("shdn_release_level", 16'(shutdown), 16'h0);
        check("shdn_release_gain_a", 16'(gain_a), 16'h0);
        check("shdn_release_gain_b", 16'(gain_b), 16'h0);
        check("shdn_release_dout", 16'(spi_bus.amp_dout), 16'h0);

        // Frame started during shutdown is ignored entirely
        spi_bus.amp_shdn = 1'b1;
        wait_clk(8);
        frame_start();
        send_bits(16'h0044, 8, 8'h00, 1'b0);
        frame_end();
        spi_bus.amp_shdn = 1'b0;
        wait_clk(8);
        check("shdn_frame_gain_a", 16'(gain_a), 16'h0);
        check("shdn_frame_gain_b", 16'(gain_b), 16'h0);

        // Load nonzero gains, then reset in the middle of the next frame
        sb_q.push_back('{1'b1, 1'b0, GAIN_M50, GAIN_M50});
        frame_start();
        send_bits(16'h0066, 8, 8'h00, 1'b1);
        frame_end();
        check("pre_reset_gain_a", 16'(gain_a), 16'(GAIN_M50));
        frame_start();
        send_bits(16'h00A5, 4, 8'h66, 1'b1);
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_frame_reset");
        wait_clk(3);
        reset_n = 1'b1;
        send_bits(16'h0005, 4, 8'h00, 1'b0);
        frame_end();
        check("post_reset_gain_a", 16'(gain_a), 16'h0);
        check("post_reset_gain_b", 16'(gain_b), 16'h0);

        // Clean frame after reset
        sb_q.push_back('{1'b1, 1'b0, GAIN_M2, GAIN_M2});
        frame_start();
        send_bits(16'h0022, 8, 8'h00, 1'b1);
        frame_end();
        check("final_gain_a", 16'(gain_a), 16'(GAIN_M2));
        check("final_gain_b", 16'(gain_b), 16'(GAIN_M2));
        check("final_queue_empty", 16'(sb_q.size()), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
